// File: rtl/gf180mcu_fd_sc_mcu7t5v0__deser4_func.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__deser4_func
//
// Functional model of a 1-to-4 deserializer. Serial bits are accepted on a
// DV/DRDY handshake and gathered into a 4-bit word. The word is presented
// on a QV/QRDY handshake. QZN is the NAND4 of the held word, so this block
// can feed the 4-input reduction cells in mixed cell-level simulations.
//
// The bit counter CNT is the state machine (S0..S3). Bits 0..2 of a word
// wait in a 3-bit staging register. The 4th accepted bit is merged with
// the staged bits directly into Q, so no extra cycle of latency is added.
// A new word may be collected while the previous one waits downstream.
// Only the completing 4th bit stalls until the held word is drained.
//
// Next-state logic uses boolean and ?: forms rather than if/else. An
// unknown handshake input therefore propagates into Q/QV/CNT in a 4-state
// simulation instead of silently selecting one branch.
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__deser4_func #(
    parameter bit MSB_FIRST = 1'b0   // 0: first bit -> Q[0]; 1: first bit -> Q[3]
) (
    input  logic       CLK,          // rising-edge clock
    input  logic       RN,           // asynchronous active-low reset
    input  logic       D,            // serial data bit
    input  logic       DV,           // D is valid this cycle
    output logic       DRDY,         // block can accept D this cycle
    input  logic       FLUSH,        // synchronous clear of partial and held word
    output logic [3:0] Q,            // assembled word (registered)
    output logic       QV,           // Q holds a valid word
    input  logic       QRDY,         // downstream accepts Q this cycle
    output logic       QZN,          // NAND4 of registered Q
    output logic [1:0] CNT           // bits collected toward the next word
);

    // -----------------------------------------------------------------------
    // FSM state encoding: the state is the number of bits already staged.
    // -----------------------------------------------------------------------
    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    // -----------------------------------------------------------------------
    // Bit placement helpers.
    // Staging layout:
    //   LSB-first: SR[k]   holds bit k, and the word is {D, SR}.
    //   MSB-first: SR[2-k] holds bit k, and the word is {SR, D}.
    // With this layout the 4th accept assembles the word by concatenation.
    // -----------------------------------------------------------------------
    function automatic logic [2:0] stage_bit(
        input logic [2:0] sr,
        input logic [1:0] k,
        input logic       d
    );
        logic [2:0] res;
        res = sr;
        case (k)
            S0:      if (MSB_FIRST) res[2] = d; else res[0] = d;
            S1:      res[1] = d;
            S2:      if (MSB_FIRST) res[0] = d; else res[2] = d;
            default: res = sr;   // the S3 accept loads Q, not the stage
        endcase
        return res;
    endfunction

    // Merge the staged bits with the completing 4th bit into a word.
    function automatic logic [3:0] assemble_word(
        input logic [2:0] sr,
        input logic       d
    );
        return MSB_FIRST ? {sr, d} : {d, sr};
    endfunction

    // -----------------------------------------------------------------------
    // State registers and their next-state values.
    // -----------------------------------------------------------------------
    logic [1:0] cnt_q, cnt_d;
    logic [2:0] sr_q,  sr_d;
    logic [3:0] q_q,   q_d;
    logic       qv_q,  qv_d;

    // Handshake decodes.
    logic drdy_s;
    logic accept_s;
    logic drain_s;
    logic load_s;

    // Handshake decode: only the completing 4th bit stalls against a held word.
    always_comb begin
        drdy_s   = ~(qv_q & ~QRDY & (cnt_q == S3));
        accept_s = DV & drdy_s & ~FLUSH;
        drain_s  = qv_q & QRDY & ~FLUSH;
        load_s   = accept_s & (cnt_q == S3);
    end

    // Next-state logic: FLUSH takes priority over accept and drain, load over drain.
    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        q_d   = q_q;
        qv_d  = qv_q;

        // The counter wraps S3 -> S0 on the load accept.
        cnt_d = FLUSH ? S0 : (cnt_q + {1'b0, accept_s});

        // The stage clears when a word loads or on a flush.
        sr_d  = (FLUSH | load_s) ? 3'b000
              : (accept_s ? stage_bit(sr_q, cnt_q, D) : sr_q);

        // Q keeps its last value on a flush. Only QV is dropped.
        q_d   = load_s ? assemble_word(sr_q, D) : q_q;

        // QV is set by a load, else cleared by a drain, else held.
        qv_d  = ~FLUSH & (load_s | (qv_q & ~drain_s));
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            cnt_q <= S0;
            sr_q  <= 3'b000;
            q_q   <= 4'h0;
            qv_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
            q_q   <= q_d;
            qv_q  <= qv_d;
        end
    end

    // Output mapping: Q/QV/CNT come from flops, while DRDY and QZN are decoded from them.
    always_comb begin
        Q    = q_q;
        QV   = qv_q;
        CNT  = cnt_q;
        DRDY = drdy_s;
        QZN  = ~(&q_q);
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__deser4_func.sv
// ---------------------------------------------------------------------------
// Testbench for gf180mcu_fd_sc_mcu7t5v0__deser4_func.
// Two instances (LSB-first and MSB-first) share one stimulus stream. Each
// table row holds the inputs for one cycle, the DRDY expected before the
// edge, and the CNT/QV/Q values expected after the edge for both orders.
// A hand-written sequence covers the asynchronous reset pulse mid-word.
// ---------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu7t5v0__deser4_func;

    logic       clk;
    logic       rn;
    logic       d, dv, flush, qrdy;
    logic       drdy0, qv0, qzn0;
    logic       drdy1, qv1, qzn1;
    logic [3:0] q0, q1;
    logic [1:0] cnt0, cnt1;

    int checks;
    int errors;

    typedef struct {
        logic       dv;
        logic       d;
        logic       qrdy;
        logic       flush;
        logic       drdy;   // expected before the edge
        logic [1:0] cnt;    // expected after the edge
        logic       qv;
        logic [3:0] q0;     // LSB-first word
        logic [3:0] q1;     // MSB-first word
    } vec_t;

    vec_t vecs[$];

    gf180mcu_fd_sc_mcu7t5v0__deser4_func #(.MSB_FIRST(1'b0)) dut0 (
        .CLK(clk), .RN(rn), .D(d), .DV(dv), .DRDY(drdy0), .FLUSH(flush),
        .Q(q0), .QV(qv0), .QRDY(qrdy), .QZN(qzn0), .CNT(cnt0)
    );

    gf180mcu_fd_sc_mcu7t5v0__deser4_func #(.MSB_FIRST(1'b1)) dut1 (
        .CLK(clk), .RN(rn), .D(d), .DV(dv), .DRDY(drdy1), .FLUSH(flush),
        .Q(q1), .QV(qv1), .QRDY(qrdy), .QZN(qzn1), .CNT(cnt1)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic dv_i, input logic d_i, input logic qrdy_i,
                       input logic flush_i, input logic drdy_i, input logic [1:0] cnt_i,
                       input logic qv_i, input logic [3:0] q0_i, input logic [3:0] q1_i);
        vec_t v;
        v.dv = dv_i; v.d = d_i; v.qrdy = qrdy_i; v.flush = flush_i;
        v.drdy = drdy_i; v.cnt = cnt_i; v.qv = qv_i; v.q0 = q0_i; v.q1 = q1_i;
        vecs.push_back(v);
    endtask

    // Called #1 after a rising edge: checks both instances after that edge.
    task automatic check_post(input string tag, input logic [1:0] ecnt, input logic eqv,
                              input logic [3:0] eq0, input logic [3:0] eq1);
        logic [3:0] nz0;
        logic [3:0] nz1;
        nz0 = {3'b000, ~(&eq0)};
        nz1 = {3'b000, ~(&eq1)};
        chk({tag, " cnt0"}, {2'b00, cnt0}, {2'b00, ecnt});
        chk({tag, " cnt1"}, {2'b00, cnt1}, {2'b00, ecnt});
        chk({tag, " qv0"},  {3'b000, qv0}, {3'b000, eqv});
        chk({tag, " qv1"},  {3'b000, qv1}, {3'b000, eqv});
        chk({tag, " q0"},   q0, eq0);
        chk({tag, " q1"},   q1, eq1);
        chk({tag, " qzn0"}, {3'b000, qzn0}, nz0);
        chk({tag, " qzn1"}, {3'b000, qzn1}, nz1);
    endtask

    // Drive one cycle, check DRDY before the edge and the state after it.
    task automatic apply(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        dv = v.dv; d = v.d; qrdy = v.qrdy; flush = v.flush;
        #1;
        chk({tag, " drdy0"}, {3'b000, drdy0}, {3'b000, v.drdy});
        chk({tag, " drdy1"}, {3'b000, drdy1}, {3'b000, v.drdy});
        @(posedge clk);
        #1;
        check_post(tag, v.cnt, v.qv, v.q0, v.q1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rn = 1'b0; d = 1'b0; dv = 1'b0; flush = 1'b0; qrdy = 1'b0;

        //   dv    d     qrdy  flush drdy  cnt    qv    q0       q1
        // Streaming 1,0,1,1 then 1,1,1,1 with QRDY=1
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000, 4'b0000);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0000, 4'b0000);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b1101, 4'b1011);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b1101, 4'b1011);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 4'b1101, 4'b1011);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 4'b1101, 4'b1011);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b1111, 4'b1111);
        // Drain the 4'hF word with no new bit
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 4'b1111, 4'b1111);
        // Backpressure: 0,1,1,0 then 1,1,0 stage; the 8th bit 0 stalls, then drain+load
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'b1111, 4'b1111);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'b1111, 4'b1111);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 4'b1111, 4'b1111);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0110, 4'b0110);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0110, 4'b0110);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0110, 4'b0110);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0110, 4'b0110);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0110, 4'b0110);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0011, 4'b1100);
        // DV gaps with junk D: valid bits 1,0,1,0
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0011, 4'b1100);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0011, 4'b1100);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0011, 4'b1100);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0011, 4'b1100);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0011, 4'b1100);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0011, 4'b1100);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0101, 4'b1010);
        // Flush at CNT=2 with QV=1: the bit is dropped and Q is retained
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0101, 4'b1010);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0101, 4'b1010);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0101, 4'b1010);
        // Word 0,0,0,1 then 1,0,0,0
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0101, 4'b1010);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0101, 4'b1010);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0101, 4'b1010);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b1000, 4'b0001);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b1000, 4'b0001);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 4'b1000, 4'b0001);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 4'b1000, 4'b0001);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b1000);
        // Two bits with QRDY=0 before the mid-word reset
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0001, 4'b1000);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0001, 4'b1000);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_post("reset", 2'd0, 1'b0, 4'h0, 4'h0);
        chk("reset drdy0", {3'b000, drdy0}, 4'b0001);
        rn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply(i, vecs[i]);

        // Asynchronous reset pulse between edges, with CNT=2 and QV=1
        dv = 1'b0; qrdy = 1'b0;
        #2;
        rn = 1'b0;
        #1;
        check_post("async", 2'd0, 1'b0, 4'h0, 4'h0);
        chk("async drdy0", {3'b000, drdy0}, 4'b0001);
        chk("async drdy1", {3'b000, drdy1}, 4'b0001);
        #1;
        rn = 1'b1;
        @(posedge clk);
        #1;
        // A fresh word 1,1,0,1 after the reset
        apply(100, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000});
        apply(101, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000, 4'b0000});
        apply(102, '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0000, 4'b0000});
        apply(103, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b1011, 4'b1101});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
